// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer for an N_PIX pixel array with per-pixel single-slope ADC:
// erase -> expose -> convert, then one-hot readout streamed over valid/ready.
module pixel_frame_sequencer #(
  parameter int N_PIX       = 4,
  parameter int ADC_W       = 8,
  parameter int ERASE_CYC   = 5,
  parameter int CONVERT_CYC = 255,
  parameter int EXP_W       = 16,
  localparam int IDX_W      = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             cont_mode,
  input  logic [EXP_W-1:0] exp_cyc,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic [N_PIX-1:0] read,
  input  logic [ADC_W-1:0] pix_data,
  output logic [ADC_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             busy,
  output logic             trig_drop
);

  localparam longint EXP_MAX  = (64'd1 << EXP_W) - 64'd1;
  localparam longint PHASE_MX = (ERASE_CYC > CONVERT_CYC) ? longint'(ERASE_CYC)
                                                          : longint'(CONVERT_CYC);
  localparam longint CNT_MAX  = (PHASE_MX > EXP_MAX) ? PHASE_MX : EXP_MAX;
  localparam int     CNT_W    = $clog2(CNT_MAX + 64'd1);

  localparam logic [CNT_W-1:0] ERASE_LOAD   = CNT_W'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0] CONVERT_LOAD = CNT_W'(CONVERT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_SETTLE, S_HOLD
  } state_t;

  // A zero exposure request still exposes for one cycle.
  function automatic logic [EXP_W-1:0] exp_len(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  function automatic logic [N_PIX-1:0] sel_onehot(input logic [IDX_W-1:0] i);
    logic [N_PIX-1:0] v;
    v = '0;
    for (int k = 0; k < N_PIX; k++) begin
      if (IDX_W'(k) == i) v[k] = 1'b1;
    end
    return v;
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [EXP_W-1:0]   exp_q;
  logic [EXP_W-1:0]   exp_d;
  logic               erase_q, expose_q, convert_q;
  logic [N_PIX-1:0]   read_q;
  logic [ADC_W-1:0]   out_data_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic               out_valid_q, frame_done_q, busy_q, trig_drop_q;

  assign exp_d = exp_len(exp_cyc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      exp_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read_q       <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      trig_drop_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // The frame_done cycle is still treated as occupied for new triggers.
      trig_drop_q  <= trigger & (busy_q | frame_done_q);
      case (state_q)
        S_IDLE: begin
          if (trigger && !frame_done_q) begin
            state_q <= S_ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= ERASE_LOAD;
            exp_q   <= exp_d;
            idx_q   <= '0;
          end
        end
        S_ERASE: begin
          if (cnt_q == '0) begin
            state_q  <= S_EXPOSE;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            cnt_q    <= CNT_W'(exp_q) - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EXPOSE: begin
          if (cnt_q == '0) begin
            state_q   <= S_CONVERT;
            expose_q  <= 1'b0;
            convert_q <= 1'b1;
            cnt_q     <= CONVERT_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CONVERT: begin
          if (cnt_q == '0) begin
            state_q   <= S_SETTLE;
            convert_q <= 1'b0;
            read_q    <= sel_onehot(idx_q);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          out_data_q  <= pix_data;
          out_idx_q   <= idx_q;
          out_valid_q <= 1'b1;
          read_q      <= '0;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q != LAST_IDX) begin
              idx_q   <= idx_q + IDX_W'(1);
              read_q  <= sel_onehot(idx_q + IDX_W'(1));
              state_q <= S_SETTLE;
            end else begin
              frame_done_q <= 1'b1;
              if (cont_mode) begin
                state_q <= S_ERASE;
                erase_q <= 1'b1;
                cnt_q   <= ERASE_LOAD;
                exp_q   <= exp_d;
                idx_q   <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          erase_q     <= 1'b0;
          expose_q    <= 1'b0;
          convert_q   <= 1'b0;
          read_q      <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read       = read_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign trig_drop  = trig_drop_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: frame-timeline model checked every cycle,
// plus hand-computed latency, strobe-length, sample and drop-count checks.
module tb_pixel_frame_sequencer;
  localparam int N_PIX = 4, ADC_W = 8, ERASE_CYC = 5, CONVERT_CYC = 255;
  localparam int EXP_W = 16, IDX_W = 2;

  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, cont_mode = 1'b0, out_ready = 1'b1;
  logic [EXP_W-1:0] exp_cyc = 16'd10;
  logic [ADC_W-1:0] pix_data;
  logic [ADC_W-1:0] pix_base = 8'hA0;
  logic erase, expose, convert, out_valid, frame_done, busy, trig_drop;
  logic [N_PIX-1:0] read;
  logic [ADC_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  int checks = 0, errors = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  pixel_frame_sequencer #(
    .N_PIX(N_PIX), .ADC_W(ADC_W), .ERASE_CYC(ERASE_CYC),
    .CONVERT_CYC(CONVERT_CYC), .EXP_W(EXP_W)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .cont_mode(cont_mode),
    .exp_cyc(exp_cyc), .erase(erase), .expose(expose), .convert(convert),
    .read(read), .pix_data(pix_data), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .busy(busy), .trig_drop(trig_drop)
  );

  // Pixel bus: the selected pixel drives base+index, otherwise a filler value.
  always_comb begin
    pix_data = 8'hEE;
    for (int i = 0; i < N_PIX; i++) begin
      if (read[i]) pix_data = pix_base + 8'(i);
    end
  end

  // Model: a frame is a timeline of strobe cycles followed by settle/hold per pixel.
  // Kinds: 0 idle, 1 erase, 2 expose, 3 convert, 4 settle, 5 hold.
  int tl[$];
  int cur = 0, pix = 0;
  logic [ADC_W-1:0] m_data = '0;
  logic [IDX_W-1:0] m_idx = '0;
  logic m_fd = 1'b0, m_drop = 1'b0;

  task automatic m_start(input int e);
    int n;
    n = (e == 0) ? 1 : e;
    tl.delete();
    for (int i = 0; i < ERASE_CYC; i++) tl.push_back(1);
    for (int i = 0; i < n; i++) tl.push_back(2);
    for (int i = 0; i < CONVERT_CYC; i++) tl.push_back(3);
    tl.push_back(4);
    pix = 0;
    cur = tl.pop_front();
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tl.delete();
      cur = 0; pix = 0; m_data = '0; m_idx = '0; m_fd = 1'b0; m_drop = 1'b0;
    end else begin
      m_drop = trigger && (cur != 0 || m_fd);
      if (cur == 0) begin
        if (trigger && !m_fd) m_start(int'(exp_cyc));
        m_fd = 1'b0;
      end else if (cur == 4) begin
        m_fd = 1'b0;
        m_data = pix_base + 8'(pix);
        m_idx = 2'(pix);
        cur = 5;
      end else if (cur == 5) begin
        m_fd = 1'b0;
        if (out_ready) begin
          if (pix < N_PIX - 1) begin
            pix++;
            cur = 4;
          end else begin
            m_fd = 1'b1;
            if (cont_mode) m_start(int'(exp_cyc));
            else cur = 0;
          end
        end
      end else begin
        m_fd = 1'b0;
        cur = tl.pop_front();
      end
    end
  end

  // Statistics gathered at the clock edge that ends each cycle.
  int n_erase = 0, n_expose = 0, n_convert = 0, n_drop = 0, n_fd = 0, n_stall1 = 0, run = 0;
  int exp_runs[$];
  logic [9:0] samples[$];
  always @(posedge clk) begin
    if (erase) n_erase++;
    if (expose) n_expose++;
    if (convert) n_convert++;
    if (trig_drop) n_drop++;
    if (frame_done) n_fd++;
    if (expose) run++;
    else if (run != 0) begin exp_runs.push_back(run); run = 0; end
    if (out_valid && out_ready) samples.push_back({out_idx, out_data});
    if (out_valid && out_idx == 2'd1) n_stall1++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {erase, expose, convert, read, out_valid, out_data, out_idx,
            frame_done, busy, trig_drop};
  endfunction

  task automatic cmp();
    logic [20:0] e;
    logic [3:0] er;
    er = (cur == 4) ? 4'(1 << pix) : 4'd0;
    e = {cur == 1, cur == 2, cur == 3, er, cur == 5, m_data, m_idx, m_fd, cur != 0, m_drop};
    chk("cycle_outputs", 32'(dut_vec()), 32'(e));
  endtask

  task automatic check_zero(input string name);
    chk(name, 32'(dut_vec()), 32'd0);
  endtask

  task automatic pulse_trig();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  // Called on a negedge; returns on the first negedge the condition holds.
  task automatic wait_until(input int sel, input int budget, input string name);
    int k;
    logic hit;
    k = 0;
    hit = 1'b0;
    while (k < budget) begin
      case (sel)
        0: hit = frame_done;
        1: hit = out_valid;
        2: hit = expose;
        default: hit = convert;
      endcase
      if (hit) break;
      @(negedge clk);
      k++;
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, lat, e0, x0, c0, f0, d0, st0, r0;
    #3 rst = 1'b0;
    chk_on = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (chk_on) cmp();
      end
    join_none

    // Reset held with random inputs.
    repeat (6) begin
      @(negedge clk);
      trigger = 1'($urandom_range(0, 1));
      cont_mode = 1'($urandom_range(0, 1));
      exp_cyc = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      check_zero("reset_outputs");
    end
    trigger = 1'b0; cont_mode = 1'b0; exp_cyc = 16'd10; out_ready = 1'b1;
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    check_zero("idle_outputs");

    // Single frame, exposure 10.
    s = samples.size(); e0 = n_erase; x0 = n_expose; c0 = n_convert; f0 = n_fd;
    @(negedge clk) trigger = 1'b1;
    lat = 0;
    while (lat < 1000) begin
      @(negedge clk);
      lat++;
      trigger = 1'b0;
      if (out_valid) break;
    end
    chk("first_sample_latency", 32'(lat), 32'd272);
    wait_until(0, 100, "t2_frame_done");
    @(negedge clk);
    chk("t2_erase_cycles", 32'(n_erase - e0), 32'd5);
    chk("t2_expose_cycles", 32'(n_expose - x0), 32'd10);
    chk("t2_convert_cycles", 32'(n_convert - c0), 32'd255);
    chk("t2_frame_done_pulses", 32'(n_fd - f0), 32'd1);
    chk("t2_sample_count", 32'(samples.size() - s), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_sample", 32'(samples[s + i]), 32'({2'(i), 8'hA0 + 8'(i)}));

    // Backpressure on sample 1.
    pix_base = 8'h3C;
    s = samples.size(); st0 = n_stall1;
    pulse_trig();
    wait_until(1, 400, "t3_sample0");
    @(negedge clk);
    wait_until(1, 10, "t3_sample1");
    chk("t3_idx", 32'(out_idx), 32'd1);
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_held_data", 32'(out_data), 32'h3D);
    chk("t3_read_low", 32'(read), 32'd0);
    out_ready = 1'b1;
    wait_until(0, 100, "t3_frame_done");
    @(negedge clk);
    chk("t3_stall_cycles", 32'(n_stall1 - st0), 32'd21);
    chk("t3_sample1", 32'(samples[s + 1]), 32'({2'd1, 8'h3D}));

    // Trigger held through a whole frame.
    d0 = n_drop; f0 = n_fd;
    @(negedge clk) trigger = 1'b1;
    wait_until(0, 600, "t4_fd1");
    repeat (2) @(negedge clk);
    trigger = 1'b0;
    chk("t4_restart_busy", 32'(busy), 32'd1);
    wait_until(0, 600, "t4_fd2");
    @(negedge clk);
    chk("t4_drop_count", 32'(n_drop - d0), 32'd279);
    chk("t4_frames", 32'(n_fd - f0), 32'd2);

    // Continuous mode with exposure changes.
    pix_base = 8'h5A;
    cont_mode = 1'b1; exp_cyc = 16'd10;
    r0 = exp_runs.size();
    pulse_trig();
    wait_until(2, 20, "t5_expose");
    exp_cyc = 16'd3;
    wait_until(0, 600, "t5_fd1");
    chk("t5_busy_between", 32'(busy), 32'd1);
    exp_cyc = 16'd0;
    @(negedge clk);
    wait_until(0, 600, "t5_fd2");
    cont_mode = 1'b0;
    @(negedge clk);
    wait_until(0, 600, "t5_fd3");
    @(negedge clk);
    chk("t5_idle_after", 32'(busy), 32'd0);
    chk("t5_expose_run1", 32'(exp_runs[r0]), 32'd10);
    chk("t5_expose_run2", 32'(exp_runs[r0 + 1]), 32'd3);
    chk("t5_expose_run3", 32'(exp_runs[r0 + 2]), 32'd1);

    // Asynchronous reset during CONVERT and during HOLD.
    pix_base = 8'hC3; exp_cyc = 16'd10;
    pulse_trig();
    wait_until(3, 30, "t6_convert");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("t6_rst_convert");
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    out_ready = 1'b0;
    pulse_trig();
    wait_until(1, 400, "t6_hold");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("t6_rst_hold");
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    out_ready = 1'b1;
    s = samples.size();
    pulse_trig();
    wait_until(0, 600, "t6_frame_done");
    @(negedge clk);
    chk("t6_sample_count", 32'(samples.size() - s), 32'd4);
    chk("t6_last_sample", 32'(samples[s + 3]), 32'({2'd3, 8'hC6}));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
